coeff_load_ctrl: RTL
====================

Name: coeff_load_ctrl

Overview:
- Sequencer that loads a 71-tap FIR coefficient register array from a host byte stream.
- Accepts coefficients over a valid/ready handshake and generates the array's `addr`/`coefficient`/`write_en` write port.
- Optional symmetric mode: each received coefficient is written to tap k and its mirror tap NTAPS-1-k, so a linear-phase RRC filter loads from half the data.
- Holds the upsampling FIR (`filter_hold`) while a load session is in progress.

Parameters:
- NTAPS, 71, number of filter taps / array entries (must be >= 2)
- AW, 7, address width; 2**AW >= NTAPS
- DW, 8, coefficient width, signed two's complement

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a load session; sampled in IDLE only
- sym_en  input  1  symmetric mode select; captured on accepted start
- abort  input  1  terminate session immediately
- s_valid  input  1  host coefficient valid
- s_data  input  DW  host coefficient, signed
- s_ready  output  1  host handshake ready
- addr  output  AW  array write address
- coefficient  output  DW  array write data, signed
- write_en  output  1  array write strobe
- busy  output  1  load session active
- done  output  1  one-cycle pulse, session completed normally
- filter_hold  output  1  freeze request to the FIR datapath

Behaviour:
- Reset (async, rst_n=0): state IDLE; idx=0; sym=0; addr=0, coefficient=0, write_en=0, busy=0, done=0, filter_hold=0. s_ready=0.
- All outputs except s_ready are registered. s_ready = (state==WAIT_DATA) && !abort, combinational.
- States: IDLE, WAIT_DATA, WRITE_A, WRITE_B, DONE.
- IDLE: start=1 -> WAIT_DATA; sym<=sym_en, idx<=0. busy and filter_hold go high the cycle after start. start in any other state is ignored.
- WAIT_DATA: on s_valid && s_ready, data is captured -> WRITE_A. No handshake -> stay; no timeout.
- WRITE_A (one cycle): write_en=1, addr=idx, coefficient=captured data.
  - If sym=1 and idx != NTAPS-1-idx -> WRITE_B.
  - Else, if idx==LAST -> DONE; otherwise idx<=idx+1 -> WAIT_DATA.
- WRITE_B (one cycle): write_en=1, addr=NTAPS-1-idx, same coefficient. Then idx==LAST -> DONE, else idx<=idx+1 -> WAIT_DATA.
- LAST:
  - NTAPS-1 when sym=0: NTAPS inputs.
  - (NTAPS-1)/2, integer division, when sym=1: 36 inputs for NTAPS=71.
  - For odd NTAPS the centre tap (35) is written once, with no WRITE_B.
- DONE (one cycle): done=1, write_en=0; busy=0 and filter_hold=0 in this same cycle. Next state IDLE.
- write_en is 0 in IDLE, WAIT_DATA and DONE. addr and coefficient hold their last values when write_en=0.
- Timing:
  - Minimum spacing between accepted beats is 2 cycles (sym=0) or 3 cycles (sym=1, non-centre).
  - Full non-sym load with s_valid held high: start at cycle 0; first write at cycle 2; last write at cycle 142; done at cycle 143.
- abort=1 in any non-IDLE state: s_ready=0 that cycle, no handshake, and next state is IDLE.
  - write_en=0, busy=0, filter_hold=0 and no done pulse from the next cycle.
  - Any write already registered for the abort cycle is still issued. Array contents are left partially updated.
  - abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins. abort is only honoured in non-IDLE states.
- idx never exceeds LAST; the addr range is always 0..NTAPS-1.

Test Plan:
- Reset mid-session: pulse rst_n low while in WRITE_A at idx=10 -> all outputs 0 immediately (async), state IDLE, no further write_en.
- Non-sym full load: start, sym_en=0, stream s_data=k-35 for k=0..70 with s_valid held high -> 71 writes, addr 0..70 with matching data, write_en spacing 2 cycles, done pulse once at cycle 143, array readback equals the stream.
- Symmetric load: sym_en=1, stream 36 values v_k=k+1 -> writes pairs (k, 70-k) for k=0..34 and a single write at addr 35=36; every mirror pair is equal; total 71 writes; done after the 36th beat.
- Backpressure/gaps: random s_valid gaps of 0-5 cycles -> exactly one write per accepted beat (two in sym mode, non-centre); s_ready=0 in WRITE_A/WRITE_B/DONE/IDLE; no duplicate or dropped addresses.
- Abort: abort asserted in WAIT_DATA at idx=20 -> no handshake that cycle; IDLE next cycle; busy/filter_hold low; no done; addr 0..19 written, 20..70 unchanged. A new start then reloads from idx 0.
- Ignored start: start pulsed while busy at idx=5 -> no restart, sequence continues to completion with a single done.

Source files
------------

// File: rtl/coeff_load_ctrl.sv
// Loads an NTAPS-entry FIR coefficient array from a host byte stream, optionally
// mirroring each coefficient to tap NTAPS-1-k. One write cycle per tap; done pulses once.
// s_ready is high only in WAIT_DATA with no abort; the host may stall for any length of time.
// Ports: clk/rst_n (async active-low); start/sym_en/abort control; s_valid/s_data/s_ready
// host stream; addr/coefficient/write_en array write port; busy/done/filter_hold status.
module coeff_load_ctrl #(
    parameter int NTAPS = 71,
    parameter int AW    = 7,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sym_en,
    input  logic          abort,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] coefficient,
    output logic          write_en,
    output logic          busy,
    output logic          done,
    output logic          filter_hold
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        WRITE_A,
        WRITE_B,
        DONE
    } state_t;

    localparam logic [AW-1:0] TOP_IDX  = AW'(NTAPS - 1);
    localparam logic [AW-1:0] SYM_LAST = AW'((NTAPS - 1) / 2);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          sym_q, sym_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] coef_q, coef_d;
    logic          we_q, we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [AW-1:0] mirror_idx;
    logic          at_last;
    logic          need_b;

    assign mirror_idx = TOP_IDX - idx_q;
    assign at_last    = (idx_q == (sym_q ? SYM_LAST : TOP_IDX));
    // The centre tap of an odd-length filter is its own mirror, so it gets one write only.
    assign need_b     = sym_q && (idx_q != mirror_idx);

    assign s_ready     = (state_q == WAIT_DATA) && !abort;
    assign addr        = addr_q;
    assign coefficient = coef_q;
    assign write_en    = we_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign filter_hold = busy_q;

    // Outputs are registered decodes of the next state, so write_en is visible
    // during the WRITE_A/WRITE_B cycle and done during the DONE cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        addr_d  = addr_q;
        coef_d  = coef_q;
        we_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_DATA;
                    sym_d   = sym_en;
                    idx_d   = '0;
                end
            end
            WAIT_DATA: begin
                if (s_valid && s_ready) begin
                    state_d = WRITE_A;
                    we_d    = 1'b1;
                    addr_d  = idx_q;
                    coef_d  = s_data;
                end
            end
            WRITE_A: begin
                if (need_b) begin
                    state_d = WRITE_B;
                    we_d    = 1'b1;
                    addr_d  = mirror_idx;
                end else if (at_last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = WAIT_DATA;
                end
            end
            WRITE_B: begin
                if (at_last) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = WAIT_DATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; a write already on the port still completes.
        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            idx_d   = idx_q;
            addr_d  = addr_q;
            coef_d  = coef_q;
            we_d    = 1'b0;
        end
    end

    assign busy_d = (state_d == WAIT_DATA) || (state_d == WRITE_A) || (state_d == WRITE_B);
    assign done_d = (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sym_q   <= 1'b0;
            addr_q  <= '0;
            coef_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            addr_q  <= addr_d;
            coef_q  <= coef_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule
